// File: rtl/user_ss_loopback.sv
// AXI-Lite control/status block wrapped around a first-word-fall-through
// stream FIFO that loops ss_* to sm_* with optional XOR scrambling.
module user_ss_loopback #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int pDEPTH      = 8
) (
    input  logic                     axi_clk,
    input  logic                     axi_reset_n,
    input  logic [pADDR_WIDTH-1:0]   ls_awaddr,
    input  logic                     ls_awvalid,
    output logic                     ls_awready,
    input  logic [pDATA_WIDTH-1:0]   ls_wdata,
    input  logic [pDATA_WIDTH/8-1:0] ls_wstrb,
    input  logic                     ls_wvalid,
    output logic                     ls_wready,
    input  logic [pADDR_WIDTH-1:0]   ls_araddr,
    input  logic                     ls_arvalid,
    output logic                     ls_arready,
    output logic [pDATA_WIDTH-1:0]   ls_rdata,
    output logic                     ls_rvalid,
    input  logic                     ls_rready,
    input  logic [pDATA_WIDTH-1:0]   ss_tdata,
    input  logic [2:0]               ss_tid,
    input  logic                     ss_tlast,
    input  logic                     ss_tvalid,
    output logic                     ss_tready,
    output logic [pDATA_WIDTH-1:0]   sm_tdata,
    output logic [2:0]               sm_tid,
    output logic                     sm_tlast,
    output logic                     sm_tvalid,
    input  logic                     sm_tready,
    output logic                     user_irq,
    output logic                     hi_pri_req
);

    localparam int PTR_W   = $clog2(pDEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int ENTRY_W = pDATA_WIDTH + 4;
    localparam int STRB_W  = pDATA_WIDTH / 8;

    localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL    = pADDR_WIDTH'('h00);
    localparam logic [pADDR_WIDTH-1:0] ADDR_STATUS  = pADDR_WIDTH'('h04);
    localparam logic [pADDR_WIDTH-1:0] ADDR_THRESH  = pADDR_WIDTH'('h08);
    localparam logic [pADDR_WIDTH-1:0] ADDR_PKT_CNT = pADDR_WIDTH'('h0C);
    localparam logic [pADDR_WIDTH-1:0] ADDR_XOR_KEY = pADDR_WIDTH'('h10);

    logic                   en, xor_mode, irq_en, irq_pend;
    logic [15:0]            thresh;
    logic [31:0]            pkt_cnt;
    logic [pDATA_WIDTH-1:0] xor_key;
    logic                   wr_ready, ar_enable;
    logic                   wr_fire, irq_set, irq_clr;

    logic [ENTRY_W-1:0]     mem [pDEPTH];
    logic [PTR_W-1:0]       wr_ptr, rd_ptr;
    logic [LVL_W-1:0]       level;
    logic                   push, pop;
    logic [ENTRY_W-1:0]     push_entry;
    logic [pDATA_WIDTH-1:0] rd_mux;

    // Write channel: both ready lines pulse together once aw and w are both offered.
    assign ls_awready = wr_ready;
    assign ls_wready  = wr_ready;
    assign wr_fire    = wr_ready && ls_awvalid && ls_wvalid;
    assign irq_set    = pop && sm_tlast;
    assign irq_clr    = wr_fire && (ls_awaddr == ADDR_STATUS) && ls_wstrb[2] && ls_wdata[16];

    assign ss_tready  = en && (level < LVL_W'(pDEPTH));
    assign sm_tvalid  = (level != '0);
    assign push       = ss_tvalid && ss_tready;
    assign pop        = sm_tvalid && sm_tready;
    assign push_entry = {ss_tdata ^ (xor_mode ? xor_key : '0), ss_tid, ss_tlast};
    assign {sm_tdata, sm_tid, sm_tlast} = mem[rd_ptr];

    assign ls_arready = ar_enable && !ls_rvalid;

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            en         <= 1'b0;
            xor_mode   <= 1'b0;
            irq_en     <= 1'b0;
            irq_pend   <= 1'b0;
            thresh     <= '0;
            pkt_cnt    <= '0;
            xor_key    <= '0;
            wr_ready   <= 1'b0;
            user_irq   <= 1'b0;
            hi_pri_req <= 1'b0;
        end else begin
            wr_ready <= ls_awvalid && ls_wvalid && !wr_ready;
            if (wr_fire) begin
                case (ls_awaddr)
                    ADDR_CTRL:
                        if (ls_wstrb[0]) {irq_en, xor_mode, en} <= ls_wdata[2:0];
                    ADDR_THRESH:
                        for (int b = 0; b < 2; b++)
                            if (ls_wstrb[b]) thresh[8*b +: 8] <= ls_wdata[8*b +: 8];
                    ADDR_XOR_KEY:
                        for (int b = 0; b < STRB_W; b++)
                            if (ls_wstrb[b]) xor_key[8*b +: 8] <= ls_wdata[8*b +: 8];
                    default: ;
                endcase
            end
            // A packet completing in the same cycle as a W1C wins.
            if (irq_set)      irq_pend <= 1'b1;
            else if (irq_clr) irq_pend <= 1'b0;
            if (irq_set) pkt_cnt <= pkt_cnt + 32'd1;
            user_irq   <= irq_pend && irq_en;
            hi_pri_req <= (thresh != '0) && (16'(level) >= thresh);
        end
    end

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: storage has no reset; emptying the pointers and level is enough to discard it.
    always_ff @(posedge axi_clk) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        rd_mux = '0;
        case (ls_araddr)
            ADDR_CTRL:    rd_mux[2:0] = {irq_en, xor_mode, en};
            ADDR_STATUS:  begin
                rd_mux[15:0] = 16'(level);
                rd_mux[16]   = irq_pend;
            end
            ADDR_THRESH:  rd_mux[15:0] = thresh;
            ADDR_PKT_CNT: rd_mux[31:0] = pkt_cnt;
            ADDR_XOR_KEY: rd_mux       = xor_key;
            default: ;
        endcase
    end

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            ar_enable <= 1'b0;
            ls_rvalid <= 1'b0;
            ls_rdata  <= '0;
        end else begin
            ar_enable <= 1'b1;
            if (ls_rvalid) begin
                if (ls_rready) ls_rvalid <= 1'b0;
            end else if (ls_arvalid && ls_arready) begin
                ls_rvalid <= 1'b1;
                ls_rdata  <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_user_ss_loopback.sv
// Scoreboard bench for user_ss_loopback: stimulus queues expected stream beats
// and read data, independent monitors pop and compare on each DUT handshake.
module tb_user_ss_loopback;

    localparam logic [11:0] A_CTRL   = 12'h000;
    localparam logic [11:0] A_STATUS = 12'h004;
    localparam logic [11:0] A_THRESH = 12'h008;
    localparam logic [11:0] A_PKT    = 12'h00C;
    localparam logic [11:0] A_KEY    = 12'h010;
    localparam logic [11:0] A_UNMAP  = 12'h020;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  id;
        logic        last;
    } beat_t;

    logic        axi_clk, axi_reset_n;
    logic [11:0] ls_awaddr, ls_araddr;
    logic        ls_awvalid, ls_awready, ls_wvalid, ls_wready;
    logic [31:0] ls_wdata, ls_rdata;
    logic [3:0]  ls_wstrb;
    logic        ls_arvalid, ls_arready, ls_rvalid, ls_rready;
    logic [31:0] ss_tdata, sm_tdata;
    logic [2:0]  ss_tid, sm_tid;
    logic        ss_tlast, ss_tvalid, ss_tready;
    logic        sm_tlast, sm_tvalid, sm_tready;
    logic        user_irq, hi_pri_req;

    beat_t       exp_q[$];
    logic [31:0] rd_q[$];
    string       rd_name_q[$];
    beat_t       mon_beat;
    logic [31:0] mon_rd;
    string       mon_name;
    int          n_checks = 0;
    int          n_fail   = 0;

    user_ss_loopback #(.pADDR_WIDTH(12), .pDATA_WIDTH(32), .pDEPTH(8)) dut (
        .axi_clk(axi_clk), .axi_reset_n(axi_reset_n),
        .ls_awaddr(ls_awaddr), .ls_awvalid(ls_awvalid), .ls_awready(ls_awready),
        .ls_wdata(ls_wdata), .ls_wstrb(ls_wstrb), .ls_wvalid(ls_wvalid), .ls_wready(ls_wready),
        .ls_araddr(ls_araddr), .ls_arvalid(ls_arvalid), .ls_arready(ls_arready),
        .ls_rdata(ls_rdata), .ls_rvalid(ls_rvalid), .ls_rready(ls_rready),
        .ss_tdata(ss_tdata), .ss_tid(ss_tid), .ss_tlast(ss_tlast),
        .ss_tvalid(ss_tvalid), .ss_tready(ss_tready),
        .sm_tdata(sm_tdata), .sm_tid(sm_tid), .sm_tlast(sm_tlast),
        .sm_tvalid(sm_tvalid), .sm_tready(sm_tready),
        .user_irq(user_irq), .hi_pri_req(hi_pri_req)
    );

    initial axi_clk = 1'b0;
    always #5 axi_clk = ~axi_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 500000");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitors sample 2ns after the falling edge, well clear of both clock edges.
    always @(negedge axi_clk) begin
        #2;
        if (axi_reset_n && sm_tvalid && sm_tready) begin
            if (exp_q.size() == 0) begin
                check("stream_unexpected", {sm_tdata, sm_tid, sm_tlast}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                mon_beat = exp_q.pop_front();
                check("stream_beat", {sm_tdata, sm_tid, sm_tlast}, mon_beat);
            end
        end
        if (axi_reset_n && ls_rvalid && ls_rready) begin
            if (rd_q.size() == 0) begin
                check("read_unexpected", ls_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                mon_rd   = rd_q.pop_front();
                mon_name = rd_name_q.pop_front();
                check(mon_name, ls_rdata, mon_rd);
            end
        end
    end

    task automatic tick();
        @(posedge axi_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        bit done = 1'b0;
        ls_awaddr = a; ls_wdata = d; ls_wstrb = s;
        ls_awvalid = 1'b1; ls_wvalid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge axi_clk);
            if (ls_awready && ls_wready) done = 1'b1;
            tick();
        end
        ls_awvalid = 1'b0; ls_wvalid = 1'b0;
        check("write_handshake", done, 1);
    endtask

    task automatic axi_read(input logic [11:0] a, input logic [31:0] exp, input string name);
        bit done = 1'b0;
        rd_q.push_back(exp);
        rd_name_q.push_back(name);
        ls_araddr = a; ls_arvalid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge axi_clk);
            if (ls_arready) done = 1'b1;
            tick();
        end
        ls_arvalid = 1'b0;
        for (int i = 0; i < 20 && rd_q.size() != 0; i++) tick();
        check({name, "_returned"}, rd_q.size(), 0);
        rd_q.delete();
        rd_name_q.delete();
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [2:0] id, input logic last,
                             input logic [31:0] exp_d);
        bit done = 1'b0;
        ss_tdata = d; ss_tid = id; ss_tlast = last; ss_tvalid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge axi_clk);
            if (ss_tready) begin
                done = 1'b1;
                exp_q.push_back({exp_d, id, last});
            end
            tick();
        end
        ss_tvalid = 1'b0;
        check("push_accept", done, 1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
        check("stream_drain", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        bit done;
        axi_reset_n = 1'b1;
        ls_awaddr = '0; ls_awvalid = 1'b0; ls_wdata = '0; ls_wstrb = '0; ls_wvalid = 1'b0;
        ls_araddr = '0; ls_arvalid = 1'b0; ls_rready = 1'b1;
        ss_tdata = '0; ss_tid = '0; ss_tlast = 1'b0; ss_tvalid = 1'b0; sm_tready = 1'b0;
        #2 axi_reset_n = 1'b0;
        #2;
        check("rst_awready", ls_awready, 0);
        check("rst_arready", ls_arready, 0);
        check("rst_rvalid", ls_rvalid, 0);
        check("rst_ss_tready", ss_tready, 0);
        check("rst_sm_tvalid", sm_tvalid, 0);
        check("rst_irq", user_irq, 0);
        check("rst_hi_pri", hi_pri_req, 0);
        repeat (3) @(posedge axi_clk);
        #1 axi_reset_n = 1'b1;
        ticks(2);

        // Plain loopback of a 4-beat packet.
        axi_write(A_CTRL, 32'h1, 4'hF);
        sm_tready = 1'b1;
        for (int i = 0; i < 4; i++)
            send_beat(32'h10 + i, 3'd1, (i == 3), 32'h10 + i);
        wait_drain();
        ticks(2);
        axi_read(A_PKT, 32'd1, "pkt_cnt_first");
        check("irq_masked", user_irq, 0);
        axi_read(A_STATUS, 32'h0001_0000, "status_pend");
        axi_read(A_UNMAP, 32'h0, "unmapped_read");
        axi_write(A_STATUS, 32'h0001_0000, 4'hF);
        axi_read(A_STATUS, 32'h0, "status_w1c");
        axi_write(A_THRESH, 32'h0000_1234, 4'b0001);
        axi_read(A_THRESH, 32'h34, "thresh_strobe");
        axi_write(A_THRESH, 32'h0, 4'hF);

        // XOR scrambling and interrupt.
        axi_write(A_KEY, 32'hFFFF_0000, 4'hF);
        axi_write(A_CTRL, 32'h7, 4'hF);
        send_beat(32'h0000_1234, 3'd2, 1'b1, 32'hFFFF_1234);
        wait_drain();
        ticks(2);
        check("irq_set", user_irq, 1);
        axi_write(A_STATUS, 32'h0001_0000, 4'hF);
        ticks(2);
        check("irq_cleared", user_irq, 0);
        axi_read(A_PKT, 32'd2, "pkt_cnt_second");

        // Fill to full, threshold request.
        axi_write(A_CTRL, 32'h1, 4'hF);
        axi_write(A_THRESH, 32'd6, 4'hF);
        sm_tready = 1'b0;
        for (int i = 0; i < 5; i++) send_beat(32'h100 + i, 3'd0, 1'b0, 32'h100 + i);
        ticks(2);
        check("hi_pri_below", hi_pri_req, 0);
        send_beat(32'h105, 3'd0, 1'b0, 32'h105);
        ticks(2);
        check("hi_pri_at", hi_pri_req, 1);
        send_beat(32'h106, 3'd0, 1'b0, 32'h106);
        send_beat(32'h107, 3'd0, 1'b0, 32'h107);
        tick();
        check("full_tready", ss_tready, 0);
        axi_read(A_STATUS, 32'd8, "level_full");

        // Ninth beat waits; simultaneous push/pop across the pointer wrap.
        ss_tdata = 32'h108; ss_tid = 3'd0; ss_tlast = 1'b0; ss_tvalid = 1'b1;
        sm_tready = 1'b1;
        @(negedge axi_clk);
        check("ninth_blocked", ss_tready, 0);
        tick();
        @(negedge axi_clk);
        check("accept_after_pop", ss_tready, 1);
        exp_q.push_back({32'h108, 3'd0, 1'b0});
        tick();
        ss_tdata = 32'h109;
        @(negedge axi_clk);
        check("accept_push_pop", ss_tready, 1);
        exp_q.push_back({32'h109, 3'd0, 1'b0});
        tick();
        ss_tvalid = 1'b0; sm_tready = 1'b0;
        axi_read(A_STATUS, 32'd7, "level_steady");
        check("hi_pri_held", hi_pri_req, 1);
        sm_tready = 1'b1;
        wait_drain();
        ticks(2);
        check("hi_pri_drained", hi_pri_req, 0);
        axi_read(A_STATUS, 32'd0, "level_empty");

        // Packet end coincident with W1C: set wins.
        sm_tready = 1'b0;
        send_beat(32'h55, 3'd5, 1'b1, 32'h55);
        ls_awaddr = A_STATUS; ls_wdata = 32'h0001_0000; ls_wstrb = 4'hF;
        ls_awvalid = 1'b1; ls_wvalid = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge axi_clk);
            if (ls_awready && ls_wready) begin
                done = 1'b1;
                #1 sm_tready = 1'b1;
            end
            tick();
        end
        ls_awvalid = 1'b0; ls_wvalid = 1'b0; sm_tready = 1'b0;
        check("w1c_coincident_handshake", done, 1);
        wait_drain();
        tick();
        axi_read(A_STATUS, 32'h0001_0000, "irq_set_priority");
        axi_write(A_STATUS, 32'h0001_0000, 4'hF);
        axi_read(A_PKT, 32'd3, "pkt_cnt_third");

        // Counter wrap from a preset value.
        force dut.pkt_cnt = 32'hFFFF_FFFF;
        tick();
        release dut.pkt_cnt;
        tick();
        axi_read(A_PKT, 32'hFFFF_FFFF, "pkt_cnt_preset");
        sm_tready = 1'b1;
        send_beat(32'h77, 3'd6, 1'b1, 32'h77);
        wait_drain();
        ticks(2);
        axi_read(A_PKT, 32'h0, "pkt_cnt_wrap");

        // Reset mid-packet with five beats queued.
        sm_tready = 1'b0;
        for (int i = 0; i < 5; i++) send_beat(32'h200 + i, 3'd7, 1'b0, 32'h200 + i);
        axi_read(A_STATUS, 32'h0001_0005, "level_five");
        axi_reset_n = 1'b0;
        #2;
        check("midrst_sm_tvalid", sm_tvalid, 0);
        check("midrst_ss_tready", ss_tready, 0);
        check("midrst_awready", ls_awready, 0);
        check("midrst_arready", ls_arready, 0);
        check("midrst_rdata", ls_rdata, 0);
        exp_q.delete();
        ticks(2);
        axi_reset_n = 1'b1;
        tick();
        sm_tready = 1'b1;
        check("post_rst_sm_tvalid", sm_tvalid, 0);
        axi_read(A_CTRL, 32'h0, "post_rst_ctrl");
        axi_read(A_STATUS, 32'h0, "post_rst_status");
        axi_read(A_THRESH, 32'h0, "post_rst_thresh");
        axi_read(A_PKT, 32'h0, "post_rst_pkt_cnt");
        axi_read(A_KEY, 32'h0, "post_rst_xor_key");
        check("post_rst_hi_pri", hi_pri_req, 0);
        ticks(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
